// File: rtl/alu_pkg.sv
// Operation encodings shared by ALU control, the execute unit and the bench.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Iterative 1-bit-per-cycle logical shifter; dout is the value after the next shift step.
// A load captures the source, amount and direction; the register steps while cnt is non-zero.
module alu_serial_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               dir,
    input  logic [WIDTH-1:0]   din,
    input  logic [SHAMT_W-1:0] amt,
    output logic               busy,
    output logic               last,
    output logic [WIDTH-1:0]   dout
);

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    logic [WIDTH-1:0]   shreg;
    logic [SHAMT_W-1:0] cnt;
    logic               dir_q;

    // dir_q: 1 shifts right, 0 shifts left; both directions zero-fill.
    assign dout = dir_q ? (shreg >> 1) : (shreg << 1);
    assign busy = (cnt != '0);
    assign last = (cnt == CNT_ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
            cnt   <= '0;
            dir_q <= 1'b0;
        end else if (load) begin
            shreg <= din;
            cnt   <= amt;
            dir_q <= dir;
        end else if (busy) begin
            shreg <= dout;
            cnt   <= cnt - CNT_ONE;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic, iterative SLL/SRL, start/ready/done handshake.
// Result, zero and overflow are registered and only change on the cycle that done pulses.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         operation,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               ready,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               overflow
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             ovf_add;
    logic             ovf_sub;
    logic             lt;
    logic [WIDTH-1:0] op_result;
    logic             op_ovf;

    logic             accept;
    logic             sh_load;
    logic             sh_busy;
    logic             sh_last;
    logic [WIDTH-1:0] sh_dout;

    assign sum  = a + b;
    assign diff = a - b;

    // Signed overflow: judged against A's sign so SLT can reuse ovf_sub.
    assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
    assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    assign lt      = diff[WIDTH-1] ^ ovf_sub;

    always_comb begin
        op_result = '0;
        op_ovf    = 1'b0;
        case (operation)
            ALU_ADD: begin
                op_result = sum;
                op_ovf    = ovf_add;
            end
            ALU_SUB: begin
                op_result = diff;
                op_ovf    = ovf_sub;
            end
            ALU_AND: op_result = a & b;
            ALU_OR:  op_result = a | b;
            ALU_XOR: op_result = a ^ b;
            // Only reached with shamt == 0; non-zero amounts go to the serial shifter.
            ALU_SLL: op_result = b;
            ALU_SRL: op_result = b;
            ALU_SLT: op_result = {{(WIDTH-1){1'b0}}, lt};
            default: op_result = '0;
        endcase
    end

    assign accept  = (state == IDLE) && start && ready;
    assign sh_load = accept && is_shift_op(operation) && (shamt != '0);

    alu_serial_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk   (clk),
        .reset (reset),
        .load  (sh_load),
        .dir   (operation == ALU_SRL),
        .din   (b),
        .amt   (shamt),
        .busy  (sh_busy),
        .last  (sh_last),
        .dout  (sh_dout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b1;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sh_load) begin
                        state <= SHIFT;
                        ready <= 1'b0;
                    end else if (accept) begin
                        result   <= op_result;
                        zero     <= (op_result == '0);
                        overflow <= op_ovf;
                        done     <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (sh_last) begin
                        result   <= sh_dout;
                        zero     <= (sh_dout == '0);
                        overflow <= 1'b0;
                        done     <= 1'b1;
                        ready    <= 1'b1;
                        state    <= IDLE;
                    end else if (!sh_busy) begin
                        // Shifter drained without a last step: recover rather than hang.
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
